decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data/address width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port Instr_D  input  32  instruction from the fetch stage's IF/ID register.
REQ-005 The block SHALL have ports PC_D and PCPlus4_D  input  32 each  PC and PC+4 of Instr_D.
REQ-006 The block SHALL have port FlushE  input  1  bubble insert into ID/EX.
REQ-007 The block SHALL have ports RegWrite_W (input 1), RD_W (input 5) and Result_W (input 32) forming the writeback port.
REQ-008 The block SHALL have ports RD1_E, RD2_E, Imm_Ext_E, PC_E and PCPlus4_E  output  32 each  registered operands.
REQ-009 The block SHALL have ports RS1_E, RS2_E and RD_E  output  5 each  registered register indices.
REQ-010 The block SHALL have control outputs RegWrite_E (1), MemWrite_E (1), Branch_E (1), Jump_E (1), ALUSrc_E (1), ResultSrc_E (2), ALUControl_E (3) and IllegalInstr_E (1).

Function
REQ-011 The block SHALL decode the RV32I subset R-ALU (0110011), I-ALU addi (0010011), lw (0000011), sw (0100011), beq (1100011) and jal (1101111).
REQ-012 Immediates SHALL be sign-extended from bit 31 for I (lw, addi), S (sw), B (beq, bit 0 = 0) and J (jal, bit 0 = 0); the R type SHALL produce Imm_Ext 0.
REQ-013 ALUControl SHALL be 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-014 ALUControl for R type SHALL be: funct3 000 with funct7[5]=1 gives sub, funct3 000 otherwise gives add, 111 gives and, 110 gives or, 010 gives slt.
REQ-015 ALUControl SHALL be add for addi/lw/sw/jal and sub for beq.
REQ-016 ResultSrc SHALL be 00 for ALU, 01 for lw and 10 for jal (PC+4).
REQ-017 RegWrite SHALL be 1 for R, addi, lw and jal; MemWrite SHALL be 1 only for sw; ALUSrc SHALL be 1 for addi, lw and sw.
REQ-018 An unsupported opcode or unsupported R funct3 SHALL produce all control outputs 0 and IllegalInstr=1.
REQ-019 The register file SHALL be 32x32, with reads combinational on Instr_D[19:15] and [24:20].
REQ-020 The register file write SHALL occur on the rising clk when RegWrite_W=1 and RD_W!=0.
REQ-021 x0 SHALL always read 0, and a write to x0 SHALL be ignored.
REQ-022 The register file SHALL be write-through: when RegWrite_W=1, RD_W!=0 and RD_W equals a read index in the same cycle, that read SHALL return Result_W.
REQ-023 The ID/EX register SHALL capture all decoded values on every rising clk, giving 1-cycle latency from Instr_D to the *_E outputs.
REQ-024 FlushE=1 SHALL load all control outputs, IllegalInstr_E and RD_E with 0 on that edge; data fields are don't-care but SHALL be driven to 0.
REQ-025 When FlushE=1 and RegWrite_W=1 occur in the same cycle, the flush and the register file write SHALL both take effect.
REQ-026 Instr_D = 0x00000000 (the fetch-reset value) SHALL decode as illegal with controls 0, giving a safe bubble.

Reset
REQ-027 rst=0 SHALL asynchronously clear every ID/EX output to 0.
REQ-028 Reset SHALL NOT clear register file contents except x0, which is hard-wired 0.
REQ-029 After rst deasserts, the first rising edge SHALL capture a normal decode.
REQ-030 Reset asserted mid-stream SHALL drop the in-flight decode.

Structure
REQ-031 A shared package SHALL hold the opcode constants, ALUControl codes, ResultSrc codes and the ImmSrc encoding (I=00, S=01, B=10, J=11).
REQ-032 The block SHALL contain one sub-module, register_file (clk, rst, A1, A2, A3, WE3, WD3, RD1, RD2), which implements the write-through behaviour of REQ-022.
REQ-033 The main decoder and ALU decoder SHALL be combinational logic inside decode_stage.

Verification
REQ-034 After reset, Instr_D=0x00500093 (addi x1,x0,5) SHALL give, one edge later, RegWrite_E=1, ALUSrc_E=1, Imm_Ext_E=5, RD_E=1, ALUControl_E=000 and RD1_E=0.
REQ-035 With the writeback port writing x2=0xDEADBEEF in the same cycle as Instr_D=0x002101B3 (add x3,x2,x2), the next edge SHALL give RD1_E=RD2_E=0xDEADBEEF and RD_E=3.
REQ-036 Instr_D=0xFE000CE3 (beq x0,x0,-8) SHALL give Branch_E=1, Imm_Ext_E=0xFFFFFFF8, ALUControl_E=001 and RegWrite_E=0; Instr_D=0x00112223 (sw x1,4(x2)) SHALL give MemWrite_E=1 and Imm_Ext_E=4.
REQ-037 A writeback of RD_W=0, Result_W=0x12345678 followed by a read of x0 SHALL give RD1_E=0.
REQ-038 Instr_D=0x00500093 with FlushE=1 SHALL give all controls 0 and RD_E=0; Instr_D=0x0000007F SHALL give IllegalInstr_E=1 and all other controls 0.
REQ-039 Asserting rst low between clock edges while valid decodes are in flight SHALL clear all outputs to 0 immediately, without waiting for an edge, and previously written x1 SHALL still read 5 after release.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode constants for the RV32I decode stage: opcodes, ALU/result codes,
// immediate formats and the immediate extraction helper.
package decode_stage_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        result_src_t result_src;
        alu_ctrl_t   alu_control;
        logic        illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Reassembles the scattered immediate bits of each format; all formats sign from bit 31.
    function automatic logic [31:0] imm_extend(input logic [31:0] instr, input imm_src_t src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{21{instr[31]}}, instr[30:20]};
            IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32x32 register file: combinational reads with write-through, x0 hard-wired to zero.
module register_file
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] A1,
    input  logic [REG_IDX_W-1:0] A2,
    input  logic [REG_IDX_W-1:0] A3,
    input  logic                 WE3,
    input  logic [XLEN-1:0]      WD3,
    output logic [XLEN-1:0]      RD1,
    output logic [XLEN-1:0]      RD2
);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr_en;

    // Contents survive reset; only writes issued while reset is asserted are suppressed.
    assign wr_en = rst && WE3 && (A3 != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[A3] <= WD3;
        end
    end

    always_comb begin
        RD1 = '0;
        if (A1 != '0) begin
            RD1 = (wr_en && (A3 == A1)) ? WD3 : regs[A1];
        end
    end

    always_comb begin
        RD2 = '0;
        if (A2 != '0) begin
            RD2 = (wr_en && (A3 == A2)) ? WD3 : regs[A2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I-subset decode stage: main/ALU decoders, register file read and the ID/EX register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          Instr_D,
    input  logic [XLEN-1:0]      PC_D,
    input  logic [XLEN-1:0]      PCPlus4_D,
    input  logic                 FlushE,
    input  logic                 RegWrite_W,
    input  logic [REG_IDX_W-1:0] RD_W,
    input  logic [XLEN-1:0]      Result_W,
    output logic [XLEN-1:0]      RD1_E,
    output logic [XLEN-1:0]      RD2_E,
    output logic [XLEN-1:0]      Imm_Ext_E,
    output logic [XLEN-1:0]      PC_E,
    output logic [XLEN-1:0]      PCPlus4_E,
    output logic [REG_IDX_W-1:0] RS1_E,
    output logic [REG_IDX_W-1:0] RS2_E,
    output logic [REG_IDX_W-1:0] RD_E,
    output logic                 RegWrite_E,
    output logic                 MemWrite_E,
    output logic                 Branch_E,
    output logic                 Jump_E,
    output logic                 ALUSrc_E,
    output logic [1:0]           ResultSrc_E,
    output logic [2:0]           ALUControl_E,
    output logic                 IllegalInstr_E
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rd_dec;

    ctrl_t                ctrl;
    imm_src_t             imm_src;
    logic                 has_imm;
    logic [XLEN-1:0]      imm_ext;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;

    ctrl_t                ctrl_e;
    logic [XLEN-1:0]      rd1_e;
    logic [XLEN-1:0]      rd2_e;
    logic [XLEN-1:0]      imm_e;
    logic [XLEN-1:0]      pc_e;
    logic [XLEN-1:0]      pc4_e;
    logic [REG_IDX_W-1:0] rs1_e;
    logic [REG_IDX_W-1:0] rs2_e;
    logic [REG_IDX_W-1:0] rd_e;

    assign opcode = Instr_D[6:0];
    assign rd     = Instr_D[11:7];
    assign funct3 = Instr_D[14:12];
    assign rs1    = Instr_D[19:15];
    assign rs2    = Instr_D[24:20];

    register_file #(.XLEN(XLEN)) u_register_file (
        .clk (clk),
        .rst (rst),
        .A1  (rs1),
        .A2  (rs2),
        .A3  (RD_W),
        .WE3 (RegWrite_W),
        .WD3 (Result_W),
        .RD1 (rd1),
        .RD2 (rd2)
    );

    // Main and ALU decoder; anything unrecognised becomes a zero-control bubble flagged illegal.
    always_comb begin
        ctrl    = CTRL_NOP;
        imm_src = IMM_I;
        has_imm = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                case (funct3)
                    F3_ADD_SUB: ctrl.alu_control = Instr_D[30] ? ALU_SUB : ALU_ADD;
                    F3_AND:     ctrl.alu_control = ALU_AND;
                    F3_OR:      ctrl.alu_control = ALU_OR;
                    F3_SLT:     ctrl.alu_control = ALU_SLT;
                    default: begin
                        ctrl         = CTRL_NOP;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                has_imm        = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                has_imm         = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
                has_imm        = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
                imm_src          = IMM_B;
                has_imm          = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
                has_imm         = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    assign imm_ext = has_imm ? imm_extend(Instr_D, imm_src) : '0;
    assign rd_dec  = ctrl.illegal ? '0 : rd;

    // ID/EX boundary: flush and reset both produce an all-zero bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_e <= CTRL_NOP;
            rd1_e  <= '0;
            rd2_e  <= '0;
            imm_e  <= '0;
            pc_e   <= '0;
            pc4_e  <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rd_e   <= '0;
        end else if (FlushE) begin
            ctrl_e <= CTRL_NOP;
            rd1_e  <= '0;
            rd2_e  <= '0;
            imm_e  <= '0;
            pc_e   <= '0;
            pc4_e  <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rd_e   <= '0;
        end else begin
            ctrl_e <= ctrl;
            rd1_e  <= rd1;
            rd2_e  <= rd2;
            imm_e  <= imm_ext;
            pc_e   <= PC_D;
            pc4_e  <= PCPlus4_D;
            rs1_e  <= rs1;
            rs2_e  <= rs2;
            rd_e   <= rd_dec;
        end
    end

    assign RD1_E          = rd1_e;
    assign RD2_E          = rd2_e;
    assign Imm_Ext_E      = imm_e;
    assign PC_E           = pc_e;
    assign PCPlus4_E      = pc4_e;
    assign RS1_E          = rs1_e;
    assign RS2_E          = rs2_e;
    assign RD_E           = rd_e;
    assign RegWrite_E     = ctrl_e.reg_write;
    assign MemWrite_E     = ctrl_e.mem_write;
    assign Branch_E       = ctrl_e.branch;
    assign Jump_E         = ctrl_e.jump;
    assign ALUSrc_E       = ctrl_e.alu_src;
    assign ResultSrc_E    = ctrl_e.result_src;
    assign ALUControl_E   = ctrl_e.alu_control;
    assign IllegalInstr_E = ctrl_e.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized instructions against a reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr_D, PC_D, PCPlus4_D;
    logic        FlushE, RegWrite_W;
    logic [4:0]  RD_W;
    logic [31:0] Result_W;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E;
    logic [4:0]  RS1_E, RS2_E, RD_E;
    logic        RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E, IllegalInstr_E;
    logic [1:0]  ResultSrc_E;
    logic [2:0]  ALUControl_E;
    logic [10:0] dut_ctrl;

    int checks   = 0;
    int failures = 0;
    logic [31:0] mdl [32];

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
        .FlushE(FlushE), .RegWrite_W(RegWrite_W), .RD_W(RD_W), .Result_W(Result_W),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
        .Branch_E(Branch_E), .Jump_E(Jump_E), .ALUSrc_E(ALUSrc_E), .ResultSrc_E(ResultSrc_E),
        .ALUControl_E(ALUControl_E), .IllegalInstr_E(IllegalInstr_E)
    );

    always #5 clk = ~clk;

    assign dut_ctrl = {RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E,
                       ResultSrc_E, ALUControl_E, IllegalInstr_E};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        longint x;
        x = longint'(v);
        if (x >= (longint'(1) << (bits - 1))) x = x - (longint'(1) << bits);
        return 32'(x);
    endfunction

    // Expected control vector {rw,mw,br,jp,alusrc,ressrc[1:0],alu[2:0],illegal} and immediate.
    function automatic void ref_decode(input logic [31:0] ins, output logic [10:0] c, output logic [31:0] imm);
        logic rw, mw, br, jp, as, ill;
        logic [1:0] rs;
        logic [2:0] alu;
        rw = 0; mw = 0; br = 0; jp = 0; as = 0; ill = 0; rs = 2'd0; alu = 3'd0; imm = 32'd0;
        case (ins[6:0])
            7'h33: case (ins[14:12])
                3'd0: begin rw = 1; alu = ins[30] ? 3'd1 : 3'd0; end
                3'd7: begin rw = 1; alu = 3'd2; end
                3'd6: begin rw = 1; alu = 3'd3; end
                3'd2: begin rw = 1; alu = 3'd5; end
                default: ill = 1;
            endcase
            7'h13: begin rw = 1; as = 1; imm = sext(32'(ins[31:20]), 12); end
            7'h03: begin rw = 1; as = 1; rs = 2'd1; imm = sext(32'(ins[31:20]), 12); end
            7'h23: begin mw = 1; as = 1; imm = sext(32'({ins[31:25], ins[11:7]}), 12); end
            7'h63: begin br = 1; alu = 3'd1;
                         imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13); end
            7'h6F: begin rw = 1; jp = 1; rs = 2'd2;
                         imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21); end
            default: ill = 1;
        endcase
        c = {rw, mw, br, jp, as, rs, alu, ill};
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic we,
                                            input logic [4:0] rdw, input logic [31:0] res);
        if (idx == 5'd0) return 32'd0;
        if (we && rdw == idx) return res;
        return mdl[idx];
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 32'(dut_ctrl), 32'd0);
        chk({tag, "_rd1"}, RD1_E, 32'd0);
        chk({tag, "_rd2"}, RD2_E, 32'd0);
        chk({tag, "_imm"}, Imm_Ext_E, 32'd0);
        chk({tag, "_pc"}, PC_E, 32'd0);
        chk({tag, "_pc4"}, PCPlus4_E, 32'd0);
        chk({tag, "_idx"}, 32'({RS1_E, RS2_E, RD_E}), 32'd0);
    endtask

    // Drives one decode cycle (called just after a falling edge), checks after the rising edge.
    task automatic step(input logic [31:0] ins, input logic flush, input logic we,
                        input logic [4:0] rdw, input logic [31:0] res, input string tag);
        logic [10:0] ec;
        logic [31:0] eimm, erd1, erd2, pc;
        pc = $urandom() & 32'hFFFF_FFFC;
        Instr_D = ins; PC_D = pc; PCPlus4_D = pc + 32'd4; FlushE = flush;
        RegWrite_W = we; RD_W = rdw; Result_W = res;
        ref_decode(ins, ec, eimm);
        erd1 = rf_read(ins[19:15], we, rdw, res);
        erd2 = rf_read(ins[24:20], we, rdw, res);
        @(posedge clk);
        #1;
        if (flush) begin
            chk_zero({tag, "_flush"});
        end else begin
            chk({tag, "_ctrl"}, 32'(dut_ctrl), 32'(ec));
            chk({tag, "_rd1"}, RD1_E, erd1);
            chk({tag, "_rd2"}, RD2_E, erd2);
            chk({tag, "_pc"}, PC_E, pc);
            chk({tag, "_pc4"}, PCPlus4_E, pc + 32'd4);
            chk({tag, "_rs"}, 32'({RS1_E, RS2_E}), 32'({ins[19:15], ins[24:20]}));
            if (!ec[0]) begin
                chk({tag, "_imm"}, Imm_Ext_E, eimm);
                chk({tag, "_rd"}, 32'(RD_E), 32'(ins[11:7]));
            end
        end
        if (we && rdw != 5'd0) mdl[rdw] = res;
        @(negedge clk);
    endtask

    initial begin
        logic [6:0]  ops [6];
        logic [31:0] ins;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        rst = 1'b0; Instr_D = 32'd0; PC_D = 32'd0; PCPlus4_D = 32'd0; FlushE = 1'b0;
        RegWrite_W = 1'b0; RD_W = 5'd0; Result_W = 32'd0;
        #23;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 1; i < 32; i++) step(32'h0, 1'b0, 1'b1, 5'(i), $urandom(), "preload");

        rst = 1'b0; #2; rst = 1'b1;
        step(32'h00500093, 1'b0, 1'b0, 5'd0, 32'd0, "addi");
        chk("addi_imm5", Imm_Ext_E, 32'd5);
        chk("addi_rd", 32'(RD_E), 32'd1);
        chk("addi_flags", 32'({RegWrite_E, ALUSrc_E, ALUControl_E}), 32'b11_000);
        chk("addi_rd1", RD1_E, 32'd0);

        step(32'h002101B3, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF, "add_wt");
        chk("wt_rd1", RD1_E, 32'hDEADBEEF);
        chk("wt_rd2", RD2_E, 32'hDEADBEEF);
        chk("wt_rd", 32'(RD_E), 32'd3);

        step(32'hFE000CE3, 1'b0, 1'b0, 5'd0, 32'd0, "beq");
        chk("beq_flags", 32'({Branch_E, RegWrite_E, ALUControl_E}), 32'b10_001);
        chk("beq_imm", Imm_Ext_E, 32'hFFFFFFF8);
        step(32'h00112223, 1'b0, 1'b0, 5'd0, 32'd0, "sw");
        chk("sw_mw", 32'(MemWrite_E), 32'd1);
        chk("sw_imm", Imm_Ext_E, 32'd4);

        step(32'h0, 1'b0, 1'b1, 5'd0, 32'h12345678, "wr_x0");
        step(32'h00500093, 1'b0, 1'b0, 5'd0, 32'd0, "rd_x0");
        chk("x0_zero", RD1_E, 32'd0);
        step(32'h00000033, 1'b0, 1'b1, 5'd0, 32'h12345678, "wt_x0");
        chk("x0_no_wt", RD1_E, 32'd0);

        step(32'h00500093, 1'b1, 1'b0, 5'd0, 32'd0, "flush");
        step(32'h0000007F, 1'b0, 1'b0, 5'd0, 32'd0, "illegal");
        chk("illegal_flag", 32'(IllegalInstr_E), 32'd1);
        chk("illegal_ctrls", 32'(dut_ctrl[10:1]), 32'd0);

        step(32'h00500093, 1'b1, 1'b1, 5'd7, 32'hCAFEF00D, "flush_wr");
        step(32'h00700033, 1'b0, 1'b0, 5'd0, 32'd0, "rd_x7");
        chk("flush_wr_kept", RD2_E, 32'hCAFEF00D);

        step(32'h0, 1'b0, 1'b1, 5'd1, 32'd5, "wr_x1");
        Instr_D = 32'h00500093; FlushE = 1'b0; RegWrite_W = 1'b0;
        @(posedge clk);
        #1;
        chk("inflight", 32'({RegWrite_E, RD_E}), 32'({1'b1, 5'd1}));
        #2 rst = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        #1 chk_zero("post_rst");
        @(negedge clk);
        step(32'h000081B3, 1'b0, 1'b0, 5'd0, 32'd0, "x1_kept");
        chk("x1_is5", RD1_E, 32'd5);

        for (int n = 0; n < 400; n++) begin
            int k;
            ins = $urandom();
            k = $urandom_range(0, 6);
            if (k < 6) ins[6:0] = ops[k];
            else ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h37;
            step(ins, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom(), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
